bpa4: RTL and testbench

- 4-bit binary parallel adder: a[3:0] + b[3:0] + c_in produces s[3:0] and c_out.
- Operands and sum are carried as individual bit ports (a3..a0, b3..b0, s3..s0).
- Internally a ripple chain of four full adders, with the result registered on one clock.
- Used as the arithmetic leaf for lab datapaths and the bit-level adder exercise.

---
 rtl/bpa4.sv | 84 ++++++++
 tb/tb_bpa4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bpa4.sv
// ============================================================================
// Module   : bpa4
// Purpose  : 4-bit ripple-carry parallel adder with a registered sum/carry.
//            Optional macro BPA_FLAGS_EN adds registered ovf and zero flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bpa4 (
  input  logic clk,
  input  logic reset_n,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  input  logic c_in,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic c_out
`ifdef BPA_FLAGS_EN
  ,
  output logic ovf,
  output logic zero
`endif
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_s;
  logic [4:0] w_c;
  logic [3:0] r_s;
  logic       r_c_out;

  assign w_a    = {a3, a2, a1, a0};
  assign w_b    = {b3, b2, b1, b0};
  assign w_c[0] = c_in;

  // Explicit ripple of four full adders; carry i+1 depends only on stage i.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s     <= 4'b0000;
      r_c_out <= 1'b0;
    end else begin
      r_s     <= w_s;
      r_c_out <= w_c[4];
    end
  end

  assign {s3, s2, s1, s0} = r_s;
  assign c_out            = r_c_out;

`ifdef BPA_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_ovf  <= w_c[3] ^ w_c[4];
      r_zero <= (w_s == 4'b0000);
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpa4.sv
// ============================================================================
// Module   : tb_bpa4
// Purpose  : Self-checking bench for bpa4: directed literal vectors, an
//            exhaustive sweep with a reset pulse, and a randomized phase.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bpa4;

  logic       clk;
  logic       reset_n;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_cin;
  logic       s3, s2, s1, s0, c_out;
`ifdef BPA_FLAGS_EN
  logic       ovf, zero;
`endif

  int checks = 0;
  int errors = 0;

  bpa4 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a3      (r_a[3]),
    .a2      (r_a[2]),
    .a1      (r_a[1]),
    .a0      (r_a[0]),
    .b3      (r_b[3]),
    .b2      (r_b[2]),
    .b1      (r_b[1]),
    .b0      (r_b[0]),
    .c_in    (r_cin),
    .s3      (s3),
    .s2      (s2),
    .s1      (s1),
    .s0      (s0),
    .c_out   (c_out)
`ifdef BPA_FLAGS_EN
    ,
    .ovf     (ovf),
    .zero    (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the values seen at each edge.
  int         m_sum;
  int         m_sa;
  int         m_sb;
  int         m_ss;
  logic [4:0] m_exp;
  logic       m_ovf;
  logic       m_zero;

  always @(posedge clk) begin
    if (reset_n !== 1'b1) begin
      m_exp  = 5'd0;
      m_ovf  = 1'b0;
      m_zero = 1'b0;
    end else begin
      m_sum  = int'(r_a) + int'(r_b) + int'(r_cin);
      m_exp  = m_sum[4:0];
      m_sa   = (r_a > 4'd7) ? int'(r_a) - 16 : int'(r_a);
      m_sb   = (r_b > 4'd7) ? int'(r_b) - 16 : int'(r_b);
      m_ss   = m_sa + m_sb + int'(r_cin);
      m_ovf  = (m_ss > 7) || (m_ss < -8);
      m_zero = ((m_sum % 16) == 0);
    end
    #1;
    checks++;
    if ({c_out, s3, s2, s1, s0} !== m_exp) begin
      errors++;
      $display("FAIL model_sum t=%0t got=%b expected=%b", $time,
               {c_out, s3, s2, s1, s0}, m_exp);
    end
`ifdef BPA_FLAGS_EN
    checks++;
    if ({ovf, zero} !== {m_ovf, m_zero}) begin
      errors++;
      $display("FAIL model_flags t=%0t got ovf,zero=%b expected=%b", $time,
               {ovf, zero}, {m_ovf, m_zero});
    end
`endif
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic rn);
    @(negedge clk);
    r_a     = a;
    r_b     = b;
    r_cin   = cin;
    reset_n = rn;
  endtask

  // Hand-computed expectation checked just after the edge that samples it.
  task automatic lit(input string name, input logic [4:0] exp5,
                     input logic [1:0] exp_flags);
    @(posedge clk);
    #2;
    checks++;
    if ({c_out, s3, s2, s1, s0} !== exp5) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, {c_out, s3, s2, s1, s0}, exp5);
    end
`ifdef BPA_FLAGS_EN
    checks++;
    if ({ovf, zero} !== exp_flags) begin
      errors++;
      $display("FAIL %s_flags got ovf,zero=%b expected=%b", name, {ovf, zero}, exp_flags);
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    r_a     = 4'd0;
    r_b     = 4'd0;
    r_cin   = 1'b0;

    // Reset hold with live operands, then release.
    drive(4'b1010, 4'b0101, 1'b1, 1'b0);
    lit("reset_hold_1", 5'b00000, 2'b00);
    drive(4'b1010, 4'b0101, 1'b1, 1'b0);
    lit("reset_hold_2", 5'b00000, 2'b00);
    drive(4'b1010, 4'b0101, 1'b1, 1'b1);
    lit("reset_release", 5'b10000, 2'b01);

    drive(4'b0011, 4'b0101, 1'b0, 1'b1);
    lit("basic_add", 5'b01000, 2'b10);
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    lit("carry_in_only", 5'b00001, 2'b00);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1);
    lit("full_ripple", 5'b10000, 2'b01);
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    lit("max", 5'b11111, 2'b00);
    drive(4'b1111, 4'b0001, 1'b0, 1'b1);
    lit("wrap", 5'b10000, 2'b01);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    lit("all_zero", 5'b00000, 2'b01);
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    lit("pos_overflow", 5'b01000, 2'b10);

    // Exhaustive sweep, back-to-back, with a reset pulse at combination 256.
    for (int i = 0; i < 512; i++) begin
      drive(4'(i >> 5), 4'(i >> 1), 1'(i), (i == 256) ? 1'b0 : 1'b1);
    end

    // Randomized operands with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
    end

    drive(4'd0, 4'd0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
